// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory that answers each request after a fixed latency
module data_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [31:0] mem_t [DEPTH];
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction
  mem_t mem = init_mem();
  state_t state, state_n;
  logic [3:0] cnt;
  logic accept, enter_resp, err;
  logic lat_we, c_we;
  logic [31:0] lat_addr, lat_wdata, c_addr, c_wdata;
  logic [3:0] lat_wstrb, c_wstrb;
  logic [AW-1:0] idx;
  // With LATENCY=1 the response is built on the accepting edge, so the live request is used then
  assign c_we    = accept ? req_we    : lat_we;
  assign c_addr  = accept ? req_addr  : lat_addr;
  assign c_wdata = accept ? req_wdata : lat_wdata;
  assign c_wstrb = accept ? req_wstrb : lat_wstrb;
  assign idx     = c_addr[AW+1:2];
  assign err     = c_addr[1:0] != 2'b0 || {2'b0, c_addr[31:2]} >= 32'(DEPTH);
  // next state and handshake strobes
  always_comb begin
    state_n = state;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    accept = req_ready && req_valid;
    if (accept) state_n = LATENCY == 1 ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd1) state_n = RESP;
    else if (resp_valid && resp_ready) state_n = IDLE;
    enter_resp = state != RESP && state_n == RESP;
  end
  // state register, request latch, latency counter and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        lat_we <= req_we;
        lat_addr <= req_addr;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt > 4'd1) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        resp_err <= err;
        resp_rdata <= (err || c_we) ? '0 : mem[idx];
      end
    end
  end
  // byte-lane store on the edge entering RESP; contents survive reset and aborted stores never land
  always_ff @(posedge clk) begin
    if (rst && enter_resp && c_we && !err)
      for (int b = 0; b < 4; b++)
        if (c_wstrb[b]) mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for a LATENCY=2 and a LATENCY=1 responder
module tb_data_mem_responder;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int cyc = 0, total = 0, passed = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [31:0] rdata; logic err; int acc;} exp_t;
  exp_t qa[$], qb[$];
  int b_rise[$];
  logic a_req_valid = 0, a_req_ready, a_req_we = 0, a_resp_valid, a_resp_ready = 1, a_resp_err;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_resp_rdata;
  logic [3:0] a_req_wstrb = 0;
  logic b_req_valid = 0, b_req_ready, b_req_we = 0, b_resp_valid, b_resp_ready = 1, b_resp_err;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_resp_rdata;
  logic [3:0] b_req_wstrb = 0;
  logic a_prev = 0, b_prev = 0;

  data_mem_responder #(.LATENCY(2), .DEPTH(128)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err));

  data_mem_responder #(.LATENCY(1), .DEPTH(128)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, wanted %h", name, act, exp);
  endtask

  // monitor for instance a: latency on each rising resp_valid, data on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (a_resp_valid && !a_prev) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_spurious: got resp_valid 1 with nothing outstanding, wanted 0");
      end else check("a_latency", 32'(cyc - qa[0].acc), 32'd2);
    end
    if (a_resp_valid && a_resp_ready && qa.size() > 0) begin
      e = qa.pop_front();
      check("a_rdata", a_resp_rdata, e.rdata);
      check("a_err", 32'(a_resp_err), 32'(e.err));
    end
    a_prev <= a_resp_valid;
  end

  // monitor for instance b
  always @(negedge clk) begin
    exp_t e;
    if (b_resp_valid && !b_prev) begin
      b_rise.push_back(cyc);
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_spurious: got resp_valid 1 with nothing outstanding, wanted 0");
      end else check("b_latency", 32'(cyc - qb[0].acc), 32'd1);
    end
    if (b_resp_valid && b_resp_ready && qb.size() > 0) begin
      e = qb.pop_front();
      check("b_rdata", b_resp_rdata, e.rdata);
      check("b_err", 32'(b_resp_err), 32'(e.err));
    end
    b_prev <= b_resp_valid;
  end

  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] rdata, input logic err,
                         input bit push = 1);
    int n = 0;
    @(negedge clk);
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_wstrb = wstrb; a_req_valid = 1;
    while (!a_req_ready && n < 64) begin @(negedge clk); n++; end
    if (!a_req_ready) begin
      total++;
      $display("FAIL a_accept_timeout: got req_ready 0, wanted 1");
      a_req_valid = 0;
      return;
    end
    if (push) qa.push_back('{rdata, err, cyc});
    @(posedge clk);
    #1 a_req_valid = 0;
  endtask

  task automatic issue_b(input logic [31:0] addr, input logic [31:0] rdata);
    int n = 0;
    @(negedge clk);
    b_req_we = 0; b_req_addr = addr; b_req_valid = 1;
    while (!b_req_ready && n < 64) begin @(negedge clk); n++; end
    if (!b_req_ready) begin
      total++;
      $display("FAIL b_accept_timeout: got req_ready 0, wanted 1");
      b_req_valid = 0;
      return;
    end
    qb.push_back('{rdata, 1'b0, cyc});
    @(posedge clk);
    #1 b_req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 200) begin @(negedge clk); n++; end
    if (qa.size() > 0 || qb.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d/%0d pending, wanted 0/0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad;
    #1;
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_resp_rdata", a_resp_rdata, 32'd0);
    check("rst_resp_err", 32'(a_resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    issue_a(0, 32'h10, 0, 4'h0, 32'h4, 0);
    issue_a(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
    issue_a(0, 32'h20, 0, 4'h0, 32'h00BB00DD, 0);
    issue_a(0, 32'h13, 0, 4'h0, 32'h0, 1);
    issue_a(1, 32'h200, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    issue_a(0, 32'h0, 0, 4'h0, 32'h0, 0);
    issue_a(0, 32'h200, 0, 4'h0, 32'h0, 1);
    issue_a(1, 32'h30, 32'h12345678, 4'h0, 32'h0, 0);
    issue_a(0, 32'h30, 0, 4'h0, 32'hC, 0);
    issue_a(0, 32'h1FC, 0, 4'h0, 32'h7F, 0);
    issue_a(0, 32'h2, 0, 4'h0, 32'h0, 1);
    drain();
    @(posedge clk);
    #1 a_resp_ready = 0;
    issue_a(0, 32'h10, 0, 4'h0, 32'h4, 0);
    n = 0;
    while (!a_resp_valid && n < 16) begin @(negedge clk); n++; end
    check("stall_reached_resp", 32'(a_resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(a_resp_valid), 32'd1);
      check("stall_rdata", a_resp_rdata, 32'h4);
      check("stall_err", 32'(a_resp_err), 32'd0);
      check("stall_req_ready", 32'(a_req_ready), 32'd0);
      a_req_valid = (i % 2 == 0) && i < 4;
      a_req_addr = 32'h14; a_req_we = 0;
    end
    @(posedge clk);
    #1 a_resp_ready = 1;
    drain();
    repeat (3) @(negedge clk);
    issue_a(1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
    rst = 0;
    #1;
    check("abort_req_ready", 32'(a_req_ready), 32'd1);
    check("abort_resp_valid", 32'(a_resp_valid), 32'd0);
    check("abort_resp_rdata", a_resp_rdata, 32'd0);
    check("abort_resp_err", 32'(a_resp_err), 32'd0);
    @(negedge clk);
    rst = 1;
    bad = 0;
    repeat (4) begin @(negedge clk); if (a_resp_valid) bad++; end
    check("abort_no_response", 32'(bad), 32'd0);
    issue_a(0, 32'h8, 0, 4'h0, 32'h2, 0);
    drain();
    issue_b(32'h0, 32'h0);
    issue_b(32'h4, 32'h1);
    drain();
    if (b_rise.size() == 2) check("b_spacing", 32'(b_rise[1] - b_rise[0]), 32'd2);
    else begin
      total++;
      $display("FAIL b_spacing: got %0d responses, wanted 2", b_rise.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
